// File: rtl/rca_multiword_seq_pkg.sv
// rtl/rca_multiword_seq_pkg.sv - shared state encodings and sizing helper for the multi-word adder
package rca_multiword_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Index width for a word counter; never narrower than one bit so WORDS=1 still has a counter.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rca_nbit.sv
// rtl/rca_nbit.sv - combinational N-bit ripple-carry word adder
module rca_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] num1_in,
  input  logic [N-1:0] num2_in,
  input  logic         cin,
  output logic [N-1:0] sum_out,
  output logic         carry_out
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_out[i] = num1_in[i] ^ num2_in[i] ^ c[i];
    assign c[i+1]     = (num1_in[i] & num2_in[i]) | (c[i] & (num1_in[i] ^ num2_in[i]));
  end

  assign carry_out = c[N];

endmodule

// File: rtl/rca_multiword_seq.sv
// rtl/rca_multiword_seq.sv - sequential LSW-first multi-word adder built around one rca_nbit stage
module rca_multiword_seq
  import rca_multiword_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_in,
  input  logic [N*WORDS-1:0] num1_in,
  input  logic [N*WORDS-1:0] num2_in,
  input  logic               cin,
  output logic               busy_out,
  output logic               done_out,
  output logic [N*WORDS-1:0] sum_out,
  output logic               carry_out
);

  localparam int WT = N * WORDS;
  localparam int IW = clog2_min1(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [WT-1:0] a_r;
  logic [WT-1:0] b_r;
  logic          carry_r;
  logic [N-1:0]  psum [WORDS];
  logic [WT-1:0] sum_r;
  logic          carry_out_r;

  logic [N-1:0]  a_words [WORDS];
  logic [N-1:0]  b_words [WORDS];
  logic [N-1:0]  word_sum;
  logic          word_carry;
  logic [WT-1:0] full_sum;
  logic          accept;

  for (genvar w = 0; w < WORDS; w++) begin : g_words
    assign a_words[w] = a_r[w*N +: N];
    assign b_words[w] = b_r[w*N +: N];
  end

  rca_nbit #(.N(N)) u_rca (
    .num1_in   (a_words[idx]),
    .num2_in   (b_words[idx]),
    .cin       (carry_r),
    .sum_out   (word_sum),
    .carry_out (word_carry)
  );

  // On the final ADD cycle the top word comes straight from the adder; lower words are already in psum.
  always_comb begin
    full_sum = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (w == WORDS - 1) full_sum[w*N +: N] = word_sum;
      else                full_sum[w*N +: N] = psum[w];
    end
  end

  assign accept = start_in && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      carry_r     <= 1'b0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
      for (int w = 0; w < WORDS; w++) psum[w] <= '0;
    end else begin
      case (state)
        ST_ADD: begin
          psum[idx] <= word_sum;
          carry_r   <= word_carry;
          idx       <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state       <= ST_DONE;
            idx         <= '0;
            sum_r       <= full_sum;
            carry_out_r <= word_carry;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state   <= ST_ADD;
            idx     <= '0;
            a_r     <= num1_in;
            b_r     <= num2_in;
            carry_r <= cin;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_out  = (state == ST_ADD);
  assign done_out  = (state == ST_DONE);
  assign sum_out   = sum_r;
  assign carry_out = carry_out_r;

endmodule

// File: tb/tb_rca_multiword_seq.sv
// tb/tb_rca_multiword_seq.sv - randomized self-checking bench for rca_multiword_seq
module tb_rca_multiword_seq;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int WT    = N * WORDS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_in = 1'b0;
  logic [WT-1:0] num1_in = '0;
  logic [WT-1:0] num2_in = '0;
  logic          cin = 1'b0;
  logic          busy_out;
  logic          done_out;
  logic [WT-1:0] sum_out;
  logic          carry_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rca_multiword_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_in  (start_in),
    .num1_in   (num1_in),
    .num2_in   (num2_in),
    .cin       (cin),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .sum_out   (sum_out),
    .carry_out (carry_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WT:0] ref_add(input logic [WT-1:0] a, input logic [WT-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + (WT+1)'(c);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs(input bit allow_start);
    start_in = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
    num1_in  = WT'($urandom);
    num2_in  = WT'($urandom);
    cin      = 1'($urandom_range(0, 1));
  endtask

  // Launch from IDLE, wait for done with junk on the inputs, then check result, timing and hold.
  task automatic run_op(input logic [WT-1:0] a, input logic [WT-1:0] b, input logic c, input string tag);
    logic [WT:0]   exp;
    logic [WT-1:0] held_sum;
    logic          held_c;
    int            lat;
    int            nbusy;
    bit            stable;
    exp      = ref_add(a, b, c);
    held_sum = sum_out;
    held_c   = carry_out;
    start_in = 1'b1;
    num1_in  = a;
    num2_in  = b;
    cin      = c;
    tick;
    lat    = 0;
    nbusy  = 0;
    stable = 1'b1;
    while (!done_out && lat < 20) begin
      if (busy_out) nbusy++;
      if (sum_out !== held_sum || carry_out !== held_c) stable = 1'b0;
      scramble_inputs(1'b1);
      tick;
      lat++;
    end
    start_in = 1'b0;
    check({tag, "_latency"}, lat, WORDS);
    check({tag, "_busy_cycles"}, nbusy, WORDS);
    check({tag, "_no_partial"}, stable, 1);
    check({tag, "_result"}, {carry_out, sum_out}, exp);
    tick;
    check({tag, "_done_pulse"}, {busy_out, done_out}, 2'b00);
    check({tag, "_held"}, {carry_out, sum_out}, exp);
  endtask

  initial begin
    logic [WT-1:0] a;
    logic [WT-1:0] b;
    logic          c;
    logic [WT:0]   exp1;
    logic [WT:0]   exp2;
    int            lat;
    int            nbusy;
    int            dones;

    // Reset with noise on every input
    for (int i = 0; i < 2; i++) begin
      scramble_inputs(1'b1);
      tick;
    end
    check("reset_outputs", {busy_out, done_out, carry_out, sum_out}, '0);
    start_in = 1'b0;
    rst_n    = 1'b1;
    tick;
    check("reset_idle", {busy_out, done_out, carry_out, sum_out}, '0);

    run_op(16'h1234, 16'h4321, 1'b0, "t2");
    check("t2_const", {carry_out, sum_out}, 17'h05555);
    run_op(16'hFFFF, 16'h0000, 1'b1, "t3");
    check("t3_const", {carry_out, sum_out}, 17'h10000);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, "t4a");
    check("t4a_const", {carry_out, sum_out}, 17'h1FFFF);
    run_op(16'h000A, 16'h000D, 1'b0, "t4b");
    check("t4b_const", {carry_out, sum_out}, 17'h00017);

    // Back-to-back: start stays high, second operation accepted in the DONE cycle
    a = WT'($urandom); b = WT'($urandom); c = 1'($urandom_range(0, 1));
    exp1 = ref_add(a, b, c);
    start_in = 1'b1; num1_in = a; num2_in = b; cin = c;
    tick;
    lat = 0;
    while (!done_out && lat < 20) begin
      num1_in = WT'($urandom); num2_in = WT'($urandom); cin = 1'($urandom_range(0, 1));
      tick;
      lat++;
    end
    check("b2b_first_latency", lat, WORDS);
    check("b2b_first_result", {carry_out, sum_out}, exp1);
    a = WT'($urandom); b = WT'($urandom); c = 1'($urandom_range(0, 1));
    exp2 = ref_add(a, b, c);
    num1_in = a; num2_in = b; cin = c;
    tick;
    lat = 0;
    nbusy = 0;
    while (!done_out && lat < 20) begin
      if (busy_out) nbusy++;
      num1_in = WT'($urandom); num2_in = WT'($urandom); cin = 1'($urandom_range(0, 1));
      tick;
      lat++;
    end
    check("b2b_second_busy_cycles", nbusy, WORDS);
    check("b2b_second_result", {carry_out, sum_out}, exp2);
    start_in = 1'b0;
    tick;
    check("b2b_return_idle", {busy_out, done_out}, 2'b00);

    // Reset during the second ADD cycle aborts the operation
    start_in = 1'b1;
    num1_in = WT'($urandom); num2_in = WT'($urandom); cin = 1'b1;
    tick;
    start_in = 1'b0;
    tick;
    check("abort_busy_before", busy_out, 1'b1);
    rst_n = 1'b0;
    tick;
    check("abort_outputs", {busy_out, done_out, carry_out, sum_out}, '0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (done_out || busy_out) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_outputs_stay", {carry_out, sum_out}, '0);
    run_op(WT'($urandom), WT'($urandom), 1'($urandom_range(0, 1)), "after_abort");

    // Random operands, with corner values mixed in
    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0: a = '1;
        1: a = '0;
        default: a = WT'($urandom);
      endcase
      b = (i % 5 == 0) ? ~a : WT'($urandom);
      c = 1'($urandom_range(0, 1));
      run_op(a, b, c, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
